pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 17 +
 rtl/npc.sv | 31 +++
 rtl/pc_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the PC unit: next-PC source encodings, default reset PC
// and the FSM state type.
package pc_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/npc.sv
// Combinational next-PC target selection: PC+4, branch, j/jal, jr.
// All arithmetic is 32-bit modulo 2^32.
module npc
  import pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] ra,
  output logic [31:0] pc_plus4,
  output logic [31:0] target
);

  logic signed [31:0] br_offset;

  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = pc_plus4;
    case (npc_sel)
      NPC_BRANCH: if (br_taken) target = pc_plus4 + $unsigned(br_offset);
      NPC_JUMP:   target = {pc_plus4[31:28], instr_index, 2'b00};
      NPC_JR:     target = ra;
      default:    target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: PC register, RUN/HALT FSM, retire counter and target legality.
// Optional macro PC_RANGE_CHECK_EN also rejects targets outside instruction memory.
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] ra,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] retired
);

`ifdef PC_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif

  localparam logic [31:0] PC_LO = RESET_PC;
  localparam logic [31:0] PC_HI = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

  state_t      state, state_nxt;
  logic [31:0] target;
  logic [31:0] pc_nxt, retired_nxt;
  logic        misalign_nxt;
  logic        misaligned, out_of_range, illegal;

  npc u_npc (
    .pc          (pc),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .instr_index (instr_index),
    .ra          (ra),
    .pc_plus4    (pc_plus4),
    .target      (target)
  );

  assign misaligned   = (target[1:0] != 2'b00);
  assign out_of_range = (target < PC_LO) || (target > PC_HI);
  assign illegal      = misaligned || (RANGE_CHECK && out_of_range);
  assign halted       = (state == HALT);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    retired_nxt  = retired;
    misalign_nxt = misalign;
    case (state)
      RUN: begin
        if (en) begin
          if (illegal) begin
            // A faulting target is never committed; only the cause is recorded.
            state_nxt = HALT;
            if (misaligned) misalign_nxt = 1'b1;
          end else begin
            pc_nxt      = target;
            retired_nxt = retired + 32'd1;
          end
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      retired  <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      retired  <= retired_nxt;
      misalign <= misalign_nxt;
    end
  end

endmodule
